// File: rtl/data_mem_responder.sv
// Responder for the processor data-memory port: word-addressed RAM with a fixed
// number of wait states, a one-cycle dReady pulse and an error flag for rejected accesses.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dAddrErr,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BASE33    = {1'b0, BASE_ADDR};
  localparam logic [32:0] END33     = BASE33 + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic        rd_q, wr_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req, accept, go_resp;
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_rd, cur_wr;
  logic        aligned, in_range, valid, mem_we;
  logic [IDX_W-1:0] idx;

  assign req    = MemRead | MemWrite;
  assign accept = (state_q == S_IDLE) && req;

  // With no wait states the response edge is the accept edge itself, so the
  // request is taken straight from the inputs instead of the latched copy.
  assign go_resp = (NO_WAIT && accept) || ((state_q == S_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    if (state_q == S_IDLE) begin
      cur_addr  = dAddress;
      cur_wdata = dWriteData;
      cur_rd    = MemRead;
      cur_wr    = MemWrite;
    end
  end

  // 33-bit compare keeps BASE + 4*DEPTH from wrapping at the top of the map.
  assign aligned  = (cur_addr[1:0] == 2'b00);
  assign in_range = ({1'b0, cur_addr} >= BASE33) && ({1'b0, cur_addr} < END33);
  assign valid    = aligned && in_range && !(cur_rd && cur_wr);
  assign idx      = IDX_W'((cur_addr - BASE_ADDR) >> 2);
  assign mem_we   = rst && go_resp && valid && cur_wr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req) state_d = NO_WAIT ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP: state_d = S_DONE;
      // Holding here until both strobes drop stops a held strobe being re-accepted.
      S_DONE: if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      dReadData <= 32'd0;
      dReady    <= 1'b0;
      dAddrErr  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dReady   <= go_resp;
      dAddrErr <= go_resp && !valid;
      if (accept) begin
        addr_q  <= dAddress;
        wdata_q <= dWriteData;
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        cnt_q   <= WAIT_INIT;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Rejected loads return zero; a both-strobes request leaves the data alone.
      if (go_resp && cur_rd && !cur_wr) begin
        dReadData <= valid ? mem[idx] : 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= cur_wdata;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three builds (1, 0 and 15 wait states)
// driven from one linear sequence with hand-computed expectations.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        mr  [3];
  logic        mw  [3];
  logic [31:0] ad  [3];
  logic [31:0] wd  [3];
  logic [31:0] rdd [3];
  logic        rdy [3];
  logic        er  [3];
  logic [1:0]  st  [3];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  data_mem_responder #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .dAddress(ad[0]), .dWriteData(wd[0]),
    .MemRead(mr[0]), .MemWrite(mw[0]), .dReadData(rdd[0]),
    .dReady(rdy[0]), .dAddrErr(er[0]), .fsm_state(st[0]));

  data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .dAddress(ad[1]), .dWriteData(wd[1]),
    .MemRead(mr[1]), .MemWrite(mw[1]), .dReadData(rdd[1]),
    .dReady(rdy[1]), .dAddrErr(er[1]), .fsm_state(st[1]));

  data_mem_responder #(.WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .dAddress(ad[2]), .dWriteData(wd[2]),
    .MemRead(mr[2]), .MemWrite(mw[2]), .dReadData(rdd[2]),
    .dReady(rdy[2]), .dAddrErr(er[2]), .fsm_state(st[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on DUT k; the address/data inputs are scrambled after accept and
  // the strobe is held 'hold' extra cycles (with hold_d on the data bus) after dReady.
  task automatic access(input int k, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int hold, input logic [31:0] hold_d,
                        output int lat, output int pulses,
                        output logic e, output logic [31:0] q);
    lat = -1; pulses = 0; e = 1'b0; q = 32'd0;
    @(negedge clk);
    mr[k] = rd; mw[k] = wr; ad[k] = a; wd[k] = d;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (rdy[k]) begin
        lat = c; pulses++; e = er[k]; q = rdd[k];
      end
      ad[k] = a ^ 32'h0000_0004;
      wd[k] = ~d;
    end
    wd[k] = hold_d;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rdy[k]) pulses++;
    end
    mr[k] = 1'b0; mw[k] = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      if (rdy[k]) pulses++;
    end
  endtask

  int          lat, pulses, idle_pulses;
  logic        e;
  logic [31:0] q;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mr[k] = 1'b0; mw[k] = 1'b0; ad[k] = 32'd0; wd[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(rdy[0]), 32'd0);
    chk("reset_err",   32'(er[0]),  32'd0);
    chk("reset_rdata", rdd[0],      32'd0);
    chk("reset_state", 32'(st[0]),  32'd0);
    rst = 1'b1;
    idle_pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rdy[0] || rdy[1] || rdy[2]) idle_pulses++;
    end
    chk("idle_no_pulse", 32'(idle_pulses), 32'd0);
    chk("idle_rdata",    rdd[0],           32'd0);

    // Store then load on word 1
    access(0, 1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 0, 32'h0, lat, pulses, e, q);
    chk("sw1_latency", 32'(lat),    32'd2);
    chk("sw1_pulses",  32'(pulses), 32'd1);
    chk("sw1_err",     32'(e),      32'd0);
    access(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("lw1_latency", 32'(lat), 32'd2);
    chk("lw1_data",    q,        32'hDEAD_BEEF);
    chk("lw1_err",     32'(e),   32'd0);

    // Held strobe with changed data must commit once only
    access(0, 1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 5, 32'h0000_0001, lat, pulses, e, q);
    chk("hold_pulses", 32'(pulses), 32'd1);
    access(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("hold_word1",  q, 32'hDEAD_BEEF);

    // First and last word
    access(0, 1'b0, 1'b1, 32'h1001_0000, 32'h1111_1111, 0, 32'h0, lat, pulses, e, q);
    access(0, 1'b0, 1'b1, 32'h1001_03FC, 32'hA5A5_A5A5, 0, 32'h0, lat, pulses, e, q);
    chk("sw_last_err", 32'(e), 32'd0);
    access(0, 1'b1, 1'b0, 32'h1001_03FC, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("lw_last_data", q,      32'hA5A5_A5A5);
    chk("lw_last_err",  32'(e), 32'd0);

    // Rejected accesses
    access(0, 1'b1, 1'b0, 32'h1001_0002, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("misalign_err",  32'(e),   32'd1);
    chk("misalign_data", q,        32'd0);
    chk("misalign_lat",  32'(lat), 32'd2);
    access(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 0, 32'h0, lat, pulses, e, q);
    access(0, 1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("below_err",  32'(e), 32'd1);
    chk("below_data", q,      32'd0);
    access(0, 1'b0, 1'b1, 32'h1001_0400, 32'hCAFE_F00D, 0, 32'h0, lat, pulses, e, q);
    chk("end_err",    32'(e),      32'd1);
    chk("end_pulses", 32'(pulses), 32'd1);
    access(0, 1'b1, 1'b0, 32'h1001_0000, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("no_alias_word0", q, 32'h1111_1111);
    access(0, 1'b1, 1'b0, 32'h1001_03FC, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("no_alias_last", q, 32'hA5A5_A5A5);

    // Both strobes: error, no write, read data untouched
    access(0, 1'b1, 1'b1, 32'h1001_0000, 32'h2222_2222, 0, 32'h0, lat, pulses, e, q);
    chk("both_err",  32'(e), 32'd1);
    chk("both_data", q,      32'hA5A5_A5A5);
    access(0, 1'b1, 1'b0, 32'h1001_0000, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("both_nowrite", q, 32'h1111_1111);

    // Zero wait states
    access(1, 1'b0, 1'b1, 32'h1001_0010, 32'h0000_0077, 0, 32'h0, lat, pulses, e, q);
    chk("w0_sw_lat", 32'(lat), 32'd1);
    access(1, 1'b1, 1'b0, 32'h1001_0010, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("w0_lw_lat",  32'(lat), 32'd1);
    chk("w0_lw_data", q,        32'h0000_0077);

    // Fifteen wait states
    access(2, 1'b0, 1'b1, 32'h1001_0010, 32'h0000_0088, 0, 32'h0, lat, pulses, e, q);
    chk("w15_sw_lat", 32'(lat), 32'd16);
    access(2, 1'b1, 1'b0, 32'h1001_0010, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("w15_lw_lat",  32'(lat), 32'd16);
    chk("w15_lw_data", q,        32'h0000_0088);

    // Reset during the wait state of a store aborts it
    access(0, 1'b0, 1'b1, 32'h1001_0008, 32'h0BAD_C0DE, 0, 32'h0, lat, pulses, e, q);
    access(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("pre_rst_data", q, 32'h0BAD_C0DE);
    @(negedge clk);
    mw[0] = 1'b1; ad[0] = 32'h1001_0008; wd[0] = 32'h1234_5678;
    @(negedge clk);
    chk("pre_rst_state", 32'(st[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(rdy[0]), 32'd0);
    chk("rst_mid_rdata", rdd[0],      32'd0);
    chk("rst_mid_state", 32'(st[0]),  32'd0);
    idle_pulses = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (rdy[0]) idle_pulses++;
    end
    mw[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rdy[0]) idle_pulses++;
    end
    chk("rst_mid_no_pulse", 32'(idle_pulses), 32'd0);
    access(0, 1'b1, 1'b0, 32'h1001_0008, 32'h0, 0, 32'h0, lat, pulses, e, q);
    chk("rst_abort_data", q,      32'h0BAD_C0DE);
    chk("rst_abort_err",  32'(e), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
